locked_core_key_loader: RTL
===========================

# locked_core_key_loader

Parametrised key-delivery wrapper for logic-locked HLS cores with `ap_ctrl_hs` control. It sits between the host control interface and a locked core (e.g. an obfuscated `adpcm_main` instance), replacing a hard-wired `working_key` constant with a runtime-loaded key. The key arrives over a narrow valid/ready chunk port and is held in a shadow register. The core's `ap_start` and the key are gated until a complete key is loaded, so a partial key never reaches the core.

## Interface
Parameters:
- `KEY_W`, 12287: width of the core's `working_key`.
- `CHUNK_W`, 32: key load port width; 1 ≤ `CHUNK_W` ≤ `KEY_W`.
- `N_CHUNKS`, derived as ceil(`KEY_W`/`CHUNK_W`): number of key chunks; 384 at the defaults.

Ports:
- `ap_clk`  in  1  clock; all logic rising-edge.
- `ap_rst_n`  in  1  asynchronous, active-low reset.
- `ap_start`  in  1  host start request.
- `ap_done`, `ap_idle`, `ap_ready`  out  1 each  host-side status.
- `core_ap_start`  out  1  start to the locked core.
- `core_ap_done`, `core_ap_idle`, `core_ap_ready`  in  1 each  core status.
- `working_key`  out  `KEY_W`  key to the core.
- `key_data`  in  `CHUNK_W`  key chunk.
- `key_valid`  in  1  chunk valid.
- `key_ready`  out  1  loader can accept a chunk.
- `key_clear`  in  1  single-cycle request to zeroize the key.
- `key_loaded`  out  1  key complete; core enabled.
- `key_err`  out  1  checksum failure (only with `KEYLOAD_CHECKSUM_EN`).

## Operation
- States:
  - EMPTY: after reset or clear.
  - LOADING: at least one chunk accepted.
  - ARMED: key complete.
  - ERROR: checksum failure; only exists with the macro.
- Chunk transfer:
  - A chunk transfers when `key_valid & key_ready` on a rising edge.
  - Chunk *i* (counter value, 0-based) is written to shadow bits [i·`CHUNK_W` +: `CHUNK_W`].
  - Bits at or above `KEY_W` in the last chunk are discarded.
- `key_ready` is 1 in EMPTY and LOADING, and 0 in ARMED and ERROR.
- Transitions:
  - EMPTY→LOADING on the first accepted chunk.
  - Accepting chunk `N_CHUNKS`−1 moves the FSM to ARMED (or to the checksum phase with the macro).
  - When `N_CHUNKS`=1, EMPTY→ARMED directly.
- Chunk counter:
  - Width is clog2(`N_CHUNKS`+1).
  - Resets to 0 on entering EMPTY.
  - Never wraps; a further load requires a clear.
- `working_key`:
  - Equals the shadow register in ARMED.
  - Is all-zero in every other state.
- Gating:
  - `core_ap_start` = `ap_start` & ARMED.
  - In ARMED, `ap_done`/`ap_idle`/`ap_ready` pass through from the core unchanged.
  - Otherwise `ap_idle`=1, `ap_done`=0, `ap_ready`=0.
- `key_clear`:
  - Core quiet means `core_ap_idle`=1 and `core_ap_start`=0.
  - If the core is quiet, the clear takes effect next edge: shadow ← 0, counter ← 0, state ← EMPTY.
  - Otherwise the clear is latched as pending and executes on the first quiet cycle.
  - While a clear is pending, `core_ap_start` is forced to 0.
- Simultaneous clear and chunk accept in the same cycle: the clear wins and the chunk is dropped.

## Timing
- Reset values of outputs:
  - `ap_idle`=1; `ap_done`=0; `ap_ready`=0.
  - `core_ap_start`=0; `working_key`=0.
  - `key_ready`=1; `key_loaded`=0; `key_err`=0.
  - State EMPTY, clear-pending flag 0.
- Reset asserted mid-load or mid-run returns every output to its reset value immediately (asynchronously), regardless of core activity.
- Load latency: `key_loaded` and `working_key` become valid on the edge that accepts the final chunk. Minimum load time is `N_CHUNKS` cycles, back-to-back.
- Gating is combinational: `core_ap_start` and the host status outputs add zero cycles of latency.
- A clear issued with the core quiet drops `key_loaded` one edge later. A deferred clear executes on the edge after the core goes quiet.

## Configuration
- `KEYLOAD_CHECKSUM_EN` defined:
  - After chunk `N_CHUNKS`−1, the loader accepts one more chunk: the XOR of all `N_CHUNKS` raw chunks, including discarded bits.
  - On a match, the FSM goes to ARMED.
  - On a mismatch, it goes to ERROR: shadow zeroed, `key_err`=1, `key_ready`=0.
  - ERROR exits only via `key_clear` (never deferred, since the core is never started) or reset.
- `KEYLOAD_CHECKSUM_EN` undefined:
  - No checksum chunk; `key_err` is tied to 0.
  - The ERROR state and the XOR accumulator are absent.

## Test plan
All scenarios use bench parameters `KEY_W`=40, `CHUNK_W`=16 (`N_CHUNKS`=3).
- Load 0x1111, 0x2222, 0xFF33 back-to-back:
  - `key_loaded`=1 on the third accept edge.
  - `working_key`=40'h33_2222_1111; `key_ready`=0.
- `ap_start`=1 during loading: `core_ap_start`=0, `ap_idle`=1; after the load completes, `core_ap_start`=1 the same cycle.
- Pulse `key_clear` while `core_ap_idle`=0 for 10 cycles:
  - `key_loaded` stays 1 and `core_ap_start`=0 throughout.
  - The clear executes on the edge after `core_ap_idle` rises.
- `key_clear` in the same cycle as the second chunk accept: chunk dropped, state EMPTY, counter 0.
- Assert `ap_rst_n`=0 asynchronously after chunk 2 (no clock edge): all outputs at reset values immediately.
- With `KEYLOAD_CHECKSUM_EN`:
  - Checksum 0xCC00 (correct for the load above) → ARMED.
  - Checksum 0xCC01 → `key_err`=1, `working_key`=0; recovery via `key_clear`.

Source files
------------

// File: rtl/locked_core_key_loader.sv
// Runtime key loader for ap_ctrl_hs logic-locked cores: shadows a chunked key, gates start/key.
// Optional trailing XOR checksum chunk enabled by defining KEYLOAD_CHECKSUM_EN.
module locked_core_key_loader #(
  parameter int unsigned KEY_W   = 12287,
  parameter int unsigned CHUNK_W = 32
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               ap_start,
  output logic               ap_done,
  output logic               ap_idle,
  output logic               ap_ready,
  output logic               core_ap_start,
  input  logic               core_ap_done,
  input  logic               core_ap_idle,
  input  logic               core_ap_ready,
  output logic [KEY_W-1:0]   working_key,
  input  logic [CHUNK_W-1:0] key_data,
  input  logic               key_valid,
  output logic               key_ready,
  input  logic               key_clear,
  output logic               key_loaded,
  output logic               key_err
);

  localparam int unsigned N_CHUNKS = (KEY_W + CHUNK_W - 1) / CHUNK_W;
  localparam int unsigned CNT_W    = $clog2(N_CHUNKS + 1);

`ifdef KEYLOAD_CHECKSUM_EN
  typedef enum logic [2:0] {StEmpty, StLoading, StArmed, StCheck, StError} state_e;
`else
  typedef enum logic [1:0] {StEmpty, StLoading, StArmed} state_e;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_W-1:0]   shadow_q, shadow_d;
  logic               clear_pend_q, clear_pend_d;
  logic               armed, accept, clear_req, core_quiet, quiet_ok, do_clear;
  logic               chunk_we, shadow_zero;
`ifdef KEYLOAD_CHECKSUM_EN
  logic [CHUNK_W-1:0] xor_q, xor_d;
`endif

  assign armed         = (state_q == StArmed);
  assign core_ap_start = ap_start & armed & ~clear_pend_q;
  assign core_quiet    = core_ap_idle & ~core_ap_start;
`ifdef KEYLOAD_CHECKSUM_EN
  // The core is never started from ERROR, so a clear there is always immediate.
  assign quiet_ok      = core_quiet | (state_q == StError);
  assign key_ready     = (state_q == StEmpty) | (state_q == StLoading) | (state_q == StCheck);
  assign key_err       = (state_q == StError);
`else
  assign quiet_ok      = core_quiet;
  assign key_ready     = (state_q == StEmpty) | (state_q == StLoading);
  assign key_err       = 1'b0;
`endif
  assign clear_req     = key_clear | clear_pend_q;
  assign do_clear      = clear_req & quiet_ok;
  assign clear_pend_d  = clear_req & ~quiet_ok;
  assign accept        = key_valid & key_ready;

  assign key_loaded  = armed;
  assign working_key = armed ? shadow_q : '0;
  assign ap_done     = armed ? core_ap_done  : 1'b0;
  assign ap_ready    = armed ? core_ap_ready : 1'b0;
  assign ap_idle     = armed ? core_ap_idle  : 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    chunk_we    = 1'b0;
    shadow_zero = 1'b0;
`ifdef KEYLOAD_CHECKSUM_EN
    xor_d       = xor_q;
`endif
    if (do_clear) begin
      state_d     = StEmpty;
      cnt_d       = '0;
      shadow_zero = 1'b1;
`ifdef KEYLOAD_CHECKSUM_EN
      xor_d       = '0;
`endif
    end else if (accept && !clear_req) begin
      // A clear in the same cycle (immediate or pending) drops the chunk.
      case (state_q)
        StEmpty, StLoading: begin
          chunk_we = 1'b1;
          cnt_d    = cnt_q + 1'b1;
`ifdef KEYLOAD_CHECKSUM_EN
          xor_d    = xor_q ^ key_data;
          state_d  = (cnt_q == CNT_W'(N_CHUNKS - 1)) ? StCheck : StLoading;
`else
          state_d  = (cnt_q == CNT_W'(N_CHUNKS - 1)) ? StArmed : StLoading;
`endif
        end
`ifdef KEYLOAD_CHECKSUM_EN
        StCheck: begin
          if (key_data == xor_q) begin
            state_d = StArmed;
          end else begin
            state_d     = StError;
            shadow_zero = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Per-chunk write lanes; the last lane is narrowed so bits past KEY_W are dropped.
  for (genvar c = 0; c < N_CHUNKS; c++) begin : g_lane
    localparam int unsigned LO = c * CHUNK_W;
    localparam int unsigned W  = (KEY_W - LO < CHUNK_W) ? (KEY_W - LO) : CHUNK_W;
    assign shadow_d[LO +: W] = shadow_zero                           ? '0 :
                               (chunk_we && cnt_q == CNT_W'(c))      ? key_data[W-1:0] :
                                                                       shadow_q[LO +: W];
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q      <= StEmpty;
      cnt_q        <= '0;
      shadow_q     <= '0;
      clear_pend_q <= 1'b0;
`ifdef KEYLOAD_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      clear_pend_q <= clear_pend_d;
`ifdef KEYLOAD_CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

endmodule
